shift_frame_tx: RTL and testbench

Downstream serializing stage for the 5-bit shift register datapath. Accepts one 5-bit word per valid/ready handshake and transmits it on a single-wire output as a framed serial stream: start bit, five data bits in a selectable order, an optional parity bit, then a stop bit. Each bit is held for a programmable number of clock cycles, so the block paces the register's parallel result onto a slow serial link.

---
 rtl/shift_pkg.sv | 17 +
 rtl/shift_frame_tx_if.sv | 21 ++
 rtl/shift_frame_tx_bit_timer.sv | 29 ++
 rtl/shift_frame_tx.sv | 115 +++++++++++
 tb/tb_shift_frame_tx.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/shift_pkg.sv
// shift_pkg: definitions shared by the 5-bit shift register datapath and its
// serializing transmit stage.
//   SHIFT_W    : word width shared with the shift register.
//   tx_state_e : transmit frame state encoding. PARITY exists in the encoding
//                in every build; it is only reachable when the transmit stage
//                is built with SHIFT_FRAME_PARITY_EN.
package shift_pkg;
  localparam int SHIFT_W = 5;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;
endpackage

// File: rtl/shift_frame_tx_if.sv
// shift_frame_tx_if: word handshake plus serial-line status for shift_frame_tx.
//   in_data/in_msb/in_valid : word, bit order and valid from upstream.
//   in_ready                : transmitter can accept a word this cycle.
//   txd/busy/done           : serial line, frame in progress, end-of-frame pulse.
// master = upstream/observer side, slave = the transmitter.
interface shift_frame_tx_if;
  import shift_pkg::*;

  logic [SHIFT_W-1:0] in_data;
  logic               in_msb;
  logic               in_valid;
  logic               in_ready;
  logic               txd;
  logic               busy;
  logic               done;

  modport master (output in_data, in_msb, in_valid,
                  input  in_ready, txd, busy, done);
  modport slave  (input  in_data, in_msb, in_valid,
                  output in_ready, txd, busy, done);
endinterface

// File: rtl/shift_frame_tx_bit_timer.sv
// bit_timer: bit-period counter for shift_frame_tx.
//   clock, reset_n : system clock, asynchronous active-low reset.
//   clear          : synchronous clear back to 0.
//   en             : count while high.
//   wrap           : high during the last cycle (count == CLKS_PER_BIT-1) of
//                    each bit period while enabled; the counter wraps to 0 on
//                    the following edge.
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic en,
  output logic wrap
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] cnt;

  // With CLKS_PER_BIT=1 the count is pinned at 0 and wrap is simply en.
  assign wrap = en && (cnt == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)           cnt <= '0;
    else if (clear || wrap) cnt <= '0;
    else if (en)            cnt <= cnt + CW'(1);
  end
endmodule

// File: rtl/shift_frame_tx.sv
// shift_frame_tx: serializes one 5-bit word per handshake onto txd as
// start(0), five data bits (MSB- or LSB-first), optional even parity, stop(1).
// Every bit is held for CLKS_PER_BIT cycles (1..255).
//   clock, reset_n : system clock, asynchronous active-low reset.
//   bus (slave)    : in_data/in_msb/in_valid/in_ready handshake, txd, busy, done.
// Build option: define SHIFT_FRAME_PARITY_EN to insert the parity bit
// (8-bit frame); without it the frame is 7 bits and no parity logic exists.
module shift_frame_tx
  import shift_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic            clock,
  input  logic            reset_n,
  shift_frame_tx_if.slave bus
);
  tx_state_e          state, state_n;
  logic [SHIFT_W-1:0] sreg, sreg_n;
  logic [2:0]         idx, idx_n;
  logic               msb_q;
  logic               txd_q, txd_n;
  logic               ready_q, busy_q, done_q;
  logic               accept, wrap;
`ifdef SHIFT_FRAME_PARITY_EN
  logic               par_q;
`endif

  assign accept = bus.in_valid && ready_q;

  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (accept),
    .en      (state != IDLE),
    .wrap    (wrap)
  );

  always_comb begin
    state_n = state;
    sreg_n  = sreg;
    idx_n   = idx;
    case (state)
      IDLE:  if (accept) begin
               state_n = START;
               sreg_n  = bus.in_data;
               idx_n   = 3'd0;
             end
      START: if (wrap) state_n = DATA;
      DATA:  if (wrap) begin
               if (idx == 3'd4) begin
`ifdef SHIFT_FRAME_PARITY_EN
                 state_n = PARITY;
`else
                 state_n = STOP;
`endif
               end else begin
                 idx_n  = idx + 3'd1;
                 // Emitted bit always sits at bit 4 (MSB-first) or bit 0.
                 sreg_n = msb_q ? {sreg[SHIFT_W-2:0], 1'b0}
                                : {1'b0, sreg[SHIFT_W-1:1]};
               end
             end
`ifdef SHIFT_FRAME_PARITY_EN
      PARITY: if (wrap) state_n = STOP;
`endif
      STOP:  if (wrap) state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // txd is registered, so it is computed from the state being entered.
    txd_n = 1'b1;
    case (state_n)
      START:  txd_n = 1'b0;
      DATA:   txd_n = msb_q ? sreg_n[SHIFT_W-1] : sreg_n[0];
`ifdef SHIFT_FRAME_PARITY_EN
      PARITY: txd_n = par_q;
`endif
      default: txd_n = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      sreg    <= '0;
      idx     <= '0;
      msb_q   <= 1'b0;
      txd_q   <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      sreg    <= sreg_n;
      idx     <= idx_n;
      if (accept) msb_q <= bus.in_msb;
      txd_q   <= txd_n;
      ready_q <= (state_n == IDLE);
      busy_q  <= (state_n != IDLE);
      done_q  <= (state == STOP) && wrap;
    end
  end

`ifdef SHIFT_FRAME_PARITY_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    par_q <= 1'b0;
    else if (accept) par_q <= ^bus.in_data;
  end
`endif

  assign bus.txd      = txd_q;
  assign bus.in_ready = ready_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
endmodule

// File: tb/tb_shift_frame_tx.sv
// tb_shift_frame_tx: randomized + directed bench for shift_frame_tx.
// A queue of per-cycle expected line levels is the reference: each accepted
// word expands into its frame bits, each repeated CLKS_PER_BIT times. Outputs
// are compared against it on every falling edge.
module tb_shift_frame_tx;
  import shift_pkg::*;

  localparam int CPB = 4;
`ifdef SHIFT_FRAME_PARITY_EN
  localparam int NBITS = 8;
`else
  localparam int NBITS = 7;
`endif

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  shift_frame_tx_if bus();

  shift_frame_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  logic q[$];
  logic exp_done = 1'b0;

  // Bit j of the result is the j-th bit put on the wire.
  function automatic logic [7:0] frame_bits(input logic [4:0] d, input logic msb);
    logic [7:0] f;
    int p;
    f = '0;
    p = 1;                       // f[0] = start bit 0
    for (int i = 0; i < 5; i++) begin
      f[p] = msb ? d[4-i] : d[i];
      p++;
    end
`ifdef SHIFT_FRAME_PARITY_EN
    f[p] = ^d;
    p++;
`endif
    f[p] = 1'b1;
    return f;
  endfunction

  task automatic check1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: q holds the expected line level for the cycle now
  // running and every cycle after it.
  always @(posedge clock or negedge reset_n) begin
    logic       acc;
    logic       popped;
    logic [7:0] f;
    if (!reset_n) begin
      q.delete();
      exp_done = 1'b0;
    end else begin
      acc    = (q.size() == 0) && bus.in_valid;
      popped = 1'b0;
      if (q.size() != 0) begin
        void'(q.pop_front());
        popped = 1'b1;
      end
      exp_done = popped && (q.size() == 0);
      if (acc) begin
        f = frame_bits(bus.in_data, bus.in_msb);
        for (int j = 0; j < NBITS; j++)
          for (int c = 0; c < CPB; c++)
            q.push_back(f[j]);
      end
    end
  end

  always @(negedge clock) begin
    logic et;
    et = (q.size() != 0) ? q[0] : 1'b1;
    check1("txd",      bus.txd,      et);
    check1("busy",     bus.busy,     q.size() != 0);
    check1("in_ready", bus.in_ready, q.size() == 0);
    check1("done",     bus.done,     exp_done);
  end

  // Send one word, then count edges from the accept edge to the done cycle.
  task automatic send_and_time(input logic [4:0] d, input logic msb);
    int n;
    @(negedge clock);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_msb   = msb;
    @(posedge clock);
    @(negedge clock);
    bus.in_valid = 1'b0;
    bus.in_data  = 5'($urandom);
    bus.in_msb   = 1'($urandom);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clock);
      n++;
      @(negedge clock);
      if (bus.done) break;
    end
    check_int("done_latency", n, NBITS * CPB);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_msb   = 1'b0;

    // Pin the reference frame builder to hand-derived frames.
`ifdef SHIFT_FRAME_PARITY_EN
    check_int("frame_msb_10110", int'(frame_bits(5'b10110, 1'b1)), 8'hDA);
    check_int("frame_lsb_10110", int'(frame_bits(5'b10110, 1'b0)), 8'hEC);
    check_int("frame_1f",        int'(frame_bits(5'h1F,   1'b1)), 8'hFE);
    check_int("frame_00",        int'(frame_bits(5'h00,   1'b0)), 8'h80);
`else
    check_int("frame_msb_10110", int'(frame_bits(5'b10110, 1'b1)), 8'h5A);
    check_int("frame_lsb_10110", int'(frame_bits(5'b10110, 1'b0)), 8'h6C);
    check_int("frame_1f",        int'(frame_bits(5'h1F,   1'b1)), 8'h7E);
    check_int("frame_00",        int'(frame_bits(5'h00,   1'b0)), 8'h40);
`endif

    // Reset, then idle with no traffic.
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (20) @(negedge clock);

    send_and_time(5'b10110, 1'b1);
    send_and_time(5'b10110, 1'b0);

    // Back-to-back: valid held high, second word taken in the done cycle.
    begin
      logic seen;
      @(negedge clock);
      bus.in_valid = 1'b1;
      bus.in_data  = 5'h1F;
      bus.in_msb   = 1'b1;
      @(posedge clock);
      @(negedge clock);
      bus.in_data  = 5'h00;
      seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
        @(negedge clock);
        if (bus.in_ready) begin
          seen = 1'b1;
          break;
        end
      end
      check1("b2b_ready_seen", seen, 1'b1);
      @(negedge clock);
      bus.in_valid = 1'b0;
      repeat (NBITS * CPB + 4) @(negedge clock);
    end

    // Reset in the middle of the third data bit.
    @(negedge clock);
    bus.in_valid = 1'b1;
    bus.in_data  = 5'b01101;
    bus.in_msb   = 1'b0;
    @(posedge clock);
    @(negedge clock);
    bus.in_valid = 1'b0;
    repeat (3 * CPB + 1) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check1("rst_txd",   bus.txd,      1'b1);
    check1("rst_busy",  bus.busy,     1'b0);
    check1("rst_ready", bus.in_ready, 1'b1);
    check1("rst_done",  bus.done,     1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    send_and_time(5'b11001, 1'b1);

    // Random traffic, data and valid wiggling mid-frame, occasional resets.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clock);
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in_data  = 5'($urandom);
      bus.in_msb   = 1'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        #2 reset_n = 1'b0;
        #2 reset_n = 1'b1;
      end
    end

    @(negedge clock);
    bus.in_valid = 1'b0;
    repeat (NBITS * CPB + 4) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
